// File: rtl/display_sprite.sv
// display_sprite: 640x480 VGA car-dodging game with a steerable player car,
// a falling rival car, collision detection and a sticky game-over state.
module display_sprite_car #(
    parameter int MOVE_DIV = 250000,
    parameter int CAR_W    = 32,
    parameter int ROAD_L   = 160,
    parameter int ROAD_R   = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       left,
    input  logic       right,
    output logic [9:0] car_x,
    output logic [9:0] car_y
);
    localparam logic [31:0] MD_MAX = 32'(MOVE_DIV - 1);
    localparam logic [9:0]  X_MIN  = 10'(ROAD_L);
    localparam logic [9:0]  X_MAX  = 10'(ROAD_R - CAR_W);
    logic [31:0] md;
    always_ff @(posedge clk) begin
        if (rst) begin
            md    <= '0;
            car_x <= 10'd304;
            car_y <= 10'd400;
        end else if (!hold) begin
            if (left == right) md <= '0;
            else if (md == MD_MAX) begin
                md    <= '0;
                car_x <= left ? (car_x > X_MIN ? car_x - 10'd1 : car_x)
                              : (car_x < X_MAX ? car_x + 10'd1 : car_x);
            end else md <= md + 32'd1;
        end
    end
endmodule

module display_sprite_rival #(
    parameter int RIVAL_STEP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       frame,
    output logic [9:0] rival_x,
    output logic [9:0] rival_y
);
    logic [7:0]  lfsr;
    logic [7:0]  lfsr_nx;
    logic [10:0] ny;
    logic [9:0]  lane_x;
    assign lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign ny      = {1'b0, rival_y} + 11'(RIVAL_STEP);
    // lane picked by the freshly stepped LFSR, 2-bit value taken mod 3
    assign lane_x  = lfsr_nx[1:0] == 2'd1 ? 10'd304 : lfsr_nx[1:0] == 2'd2 ? 10'd432 : 10'd176;
    always_ff @(posedge clk) begin
        if (rst) begin
            rival_x <= 10'd224;
            rival_y <= 10'd0;
            lfsr    <= 8'hA5;
        end else if (frame && !hold) begin
            if (ny >= 11'd480) begin
                rival_y <= 10'd0;
                lfsr    <= lfsr_nx;
                rival_x <= lane_x;
            end else rival_y <= ny[9:0];
        end
    end
endmodule

module display_sprite #(
    parameter int PIX_DIV    = 4,
    parameter int MOVE_DIV   = 250000,
    parameter int RIVAL_STEP = 2,
    parameter int CAR_W      = 32,
    parameter int CAR_H      = 64,
    parameter int ROAD_L     = 160,
    parameter int ROAD_R     = 480
) (
    input  logic        clk,
    input  logic        BTNC,
    input  logic        BTNL,
    input  logic        BTNR,
    output logic        HS,
    output logic        VS,
    output logic [11:0] vgaRGB
);
    localparam logic [15:0] PIX_MAX = 16'(PIX_DIV - 1);
    localparam logic [10:0] W = 11'(CAR_W);
    localparam logic [10:0] H = 11'(CAR_H);
    logic [15:0] pix_cnt;
    logic [9:0]  h_cnt, v_cnt;
    logic [9:0]  car_x, car_y, rival_x, rival_y;
    logic        pix_tick, frame_tick, game_over, hit, visible;
    logic        in_car, in_rival, in_lane, in_road;
    logic [10:0] hx, vy, cx, cy, rx, ry;
    logic [11:0] colour;
    assign pix_tick   = pix_cnt == PIX_MAX;
    assign frame_tick = pix_tick && h_cnt == 10'd799 && v_cnt == 10'd524;
    assign hx = {1'b0, h_cnt};
    assign vy = {1'b0, v_cnt};
    assign cx = {1'b0, car_x};
    assign cy = {1'b0, car_y};
    assign rx = {1'b0, rival_x};
    assign ry = {1'b0, rival_y};
    assign visible  = h_cnt < 10'd640 && v_cnt < 10'd480;
    assign in_car   = hx >= cx && hx < cx + W && vy >= cy && vy < cy + H;
    assign in_rival = hx >= rx && hx < rx + W && vy >= ry && vy < ry + H;
    assign in_lane  = ((h_cnt >= 10'd266 && h_cnt < 10'd270) || (h_cnt >= 10'd372 && h_cnt < 10'd376)) && !v_cnt[5];
    assign in_road  = h_cnt >= 10'(ROAD_L) && h_cnt < 10'(ROAD_R);
    assign hit      = rx < cx + W && cx < rx + W && ry < cy + H && cy < ry + H;
    assign colour = in_car   ? 12'h00F :
                    in_rival ? 12'hFF0 :
                    in_lane  ? 12'hFFF :
                    in_road  ? (game_over ? 12'hF00 : 12'h555) : 12'h0A0;
    display_sprite_car #(.MOVE_DIV(MOVE_DIV), .CAR_W(CAR_W), .ROAD_L(ROAD_L), .ROAD_R(ROAD_R)) carfsm (
        .clk(clk), .rst(BTNC), .hold(game_over), .left(BTNL), .right(BTNR),
        .car_x(car_x), .car_y(car_y)
    );
    display_sprite_rival #(.RIVAL_STEP(RIVAL_STEP)) rival_inst (
        .clk(clk), .rst(BTNC), .hold(game_over), .frame(frame_tick),
        .rival_x(rival_x), .rival_y(rival_y)
    );
    always_ff @(posedge clk) begin
        if (BTNC) begin
            pix_cnt   <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            HS        <= 1'b1;
            VS        <= 1'b1;
            vgaRGB    <= '0;
            game_over <= 1'b0;
        end else begin
            pix_cnt <= pix_tick ? '0 : pix_cnt + 16'd1;
            if (pix_tick) begin
                h_cnt <= h_cnt == 10'd799 ? 10'd0 : h_cnt + 10'd1;
                if (h_cnt == 10'd799) v_cnt <= v_cnt == 10'd524 ? 10'd0 : v_cnt + 10'd1;
            end
            HS        <= !(h_cnt >= 10'd656 && h_cnt <= 10'd751);
            VS        <= !(v_cnt >= 10'd490 && v_cnt <= 10'd491);
            vgaRGB    <= visible ? colour : 12'h000;
            game_over <= game_over | hit;
        end
    end
endmodule

// File: tb/tb_display_sprite.sv
// tb_display_sprite: directed checks of sync timing, pixel colours, steering,
// rival frame updates and collision freeze for display_sprite.
module tb_display_sprite;
    logic        clk = 1'b0;
    logic        BTNC = 1'b1, BTNL = 1'b0, BTNR = 1'b0;
    logic        HS, VS;
    logic [11:0] vgaRGB;
    int tests = 0, fails = 0, cyc = 0, rel = 0, t0 = 0, n = 0;

    display_sprite #(.MOVE_DIV(100)) dut (
        .clk(clk), .BTNC(BTNC), .BTNL(BTNL), .BTNR(BTNR),
        .HS(HS), .VS(VS), .vgaRGB(vgaRGB)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d ('h%0h) expected %0d ('h%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_lvl(input string tag, input bit vs, input logic lvl, input int bound);
        int k = 0;
        while (((vs ? VS : HS) !== lvl) && k < bound) begin step(1); k++; end
        chk(tag, k < bound, 1);
    endtask

    task automatic px(input string tag, input logic [9:0] h, input logic [11:0] e);
        int k = 0;
        while (dut.h_cnt !== h && k < 4000) begin step(1); k++; end
        chk({tag, "_reach"}, k < 4000, 1);
        step(1);
        chk(tag, vgaRGB, e);
    endtask

    task automatic hold_btn(input logic l, input logic r, input int k);
        BTNL = l;
        BTNR = r;
        step(k);
        BTNL = 1'b0;
        BTNR = 1'b0;
    endtask

    task automatic sync_pix();
        int k = 0;
        while (dut.pix_cnt !== 16'd1 && k < 8) begin step(1); k++; end
    endtask

    task automatic frame();
        sync_pix();
        force dut.h_cnt = 10'd799;
        force dut.v_cnt = 10'd524;
        step(1);
        release dut.h_cnt;
        release dut.v_cnt;
        step(8);
    endtask

    initial begin
        step(200);
        chk("rst_hs", HS, 1);
        chk("rst_vs", VS, 1);
        chk("rst_rgb", vgaRGB, 0);
        chk("rst_h", dut.h_cnt, 0);
        chk("rst_carx", dut.carfsm.car_x, 304);
        chk("rst_cary", dut.carfsm.car_y, 400);
        chk("rst_rivx", dut.rival_inst.rival_x, 224);
        chk("rst_rivy", dut.rival_inst.rival_y, 0);
        chk("rst_go", dut.game_over, 0);
        BTNC = 1'b0;
        rel = cyc;
        px("grass", 10'd100, 12'h0A0);
        px("road", 10'd200, 12'h555);
        px("rival", 10'd230, 12'hFF0);
        px("lane", 10'd268, 12'hFFF);
        wait_lvl("hs_fall", 0, 1'b0, 5000);
        chk("hs_first", cyc - rel, 2625);
        t0 = cyc;
        wait_lvl("hs_rise", 0, 1'b1, 1000);
        chk("hs_low", cyc - t0, 384);
        wait_lvl("hs_fall2", 0, 1'b0, 4000);
        chk("hs_period", cyc - t0, 3200);
        px("blank", 10'd700, 12'h000);
        sync_pix();
        force dut.v_cnt = 10'd410;
        step(1);
        release dut.v_cnt;
        px("player", 10'd310, 12'h00F);
        sync_pix();
        force dut.v_cnt = 10'd489;
        step(1);
        release dut.v_cnt;
        wait_lvl("vs_fall", 1, 1'b0, 5000);
        t0 = cyc;
        wait_lvl("vs_rise", 1, 1'b1, 8000);
        chk("vs_low", cyc - t0, 6400);
        hold_btn(1'b1, 1'b0, 2000);
        chk("left20", dut.carfsm.car_x, 284);
        hold_btn(1'b0, 1'b1, 2000);
        chk("right20", dut.carfsm.car_x, 304);
        hold_btn(1'b1, 1'b1, 2000);
        chk("both", dut.carfsm.car_x, 304);
        hold_btn(1'b1, 1'b0, 20000);
        chk("clamp_l", dut.carfsm.car_x, 160);
        hold_btn(1'b0, 1'b1, 500);
        chk("right5", dut.carfsm.car_x, 165);
        frame();
        chk("frame1", dut.rival_inst.rival_y, 2);
        frame();
        chk("frame2", dut.rival_inst.rival_y, 4);
        force dut.rival_inst.rival_y = 10'd478;
        step(1);
        release dut.rival_inst.rival_y;
        frame();
        chk("wrap_y", dut.rival_inst.rival_y, 0);
        chk("wrap_x", dut.rival_inst.rival_x, 432);
        chk("no_go", dut.game_over, 0);
        force dut.rival_inst.rival_x = 10'd165;
        force dut.rival_inst.rival_y = 10'd410;
        step(1);
        chk("go_set", dut.game_over, 1);
        step(9);
        release dut.rival_inst.rival_x;
        release dut.rival_inst.rival_y;
        hold_btn(1'b0, 1'b1, 2000);
        frame();
        chk("frz_carx", dut.carfsm.car_x, 165);
        chk("frz_rivy", dut.rival_inst.rival_y, 410);
        chk("frz_rivx", dut.rival_inst.rival_x, 165);
        chk("go_sticky", dut.game_over, 1);
        px("road_red", 10'd200, 12'hF00);
        BTNC = 1'b1;
        step(10);
        chk("rst2_v", dut.v_cnt, 0);
        BTNC = 1'b0;
        chk("rst2_go", dut.game_over, 0);
        chk("rst2_carx", dut.carfsm.car_x, 304);
        chk("rst2_rivx", dut.rival_inst.rival_x, 224);
        chk("rst2_rivy", dut.rival_inst.rival_y, 0);
        px("road_grey", 10'd200, 12'h555);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
